equation_checker: RTL and testbench
===================================

Name: equation_checker

Overview:
- Parametrised successor to the single-equation puzzle checker in the Mathrix Mornings game.
- Per round: latches a target from the game timer, collects three operands (x, y, z) from the switches via a Go handshake, and evaluates one of four selectable equations on a shared ALU.
- Compares the result against the target and allows up to MAX_TRIES operand entries before the round is declared failed.
- Sits between the input/timer logic and the VGA status logic.

Parameters:
- W, 8: data/ALU width; all arithmetic is mod 2^W.
- TIMER_W, 7: timer width; constraint TIMER_W <= W.
- MAX_TRIES, 3: operand-entry attempts per round; must be >= 1.
- TRY_W, $clog2(MAX_TRIES+1): width of the TriesLeft output.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begins a round; sampled only in IDLE, SOLVED or FAILED.
- Mode  in  2  equation select; latched on an accepted Start.
- Go  in  1  operand-entry strobe (level).
- OngoingTimer  in  TIMER_W  current game time; latched as the target.
- DataIn  in  W  operand value.
- Busy  out  1  high in every state except IDLE, SOLVED and FAILED.
- Correct  out  1  level; high while in SOLVED.
- Wrong  out  1  one-cycle pulse on each failed compare.
- Done  out  1  level; high in SOLVED or FAILED.
- TriesLeft  out  TRY_W  remaining attempts.
- Result  out  W  last evaluated value, registered.
- Target  out  W  latched target, zero-extended.

Behaviour:
- Reset (async, any state including mid-evaluation):
  - State goes to IDLE.
  - x, y, z, t1, t2, Result, Target and mode register all 0.
  - TriesLeft = MAX_TRIES.
  - Correct, Wrong, Done, Busy all 0.
- States: IDLE, LOAD_X, WAIT_X, LOAD_Y, WAIT_Y, LOAD_Z, WAIT_Z, EVAL, CHECK, SOLVED, FAILED.
- IDLE/SOLVED/FAILED on Start=1:
  - Latch Target = zero-extended OngoingTimer.
  - Latch Mode.
  - TriesLeft = MAX_TRIES.
  - Clear Result; go to LOAD_X.
- Outside those three states, Start is ignored.
- Operand capture:
  - In LOAD_v with Go=1, capture v <= DataIn in that cycle and go to WAIT_v.
  - WAIT_v stays until Go=0, then moves to the next LOAD state (after WAIT_Z, to EVAL with step=0).
  - Go held high through entry into LOAD_X captures immediately; this is allowed.
- EVAL uses a step counter; one ALU operation per cycle, writing temporaries t1/t2 or Result.
  - Mode 0, 4 steps, x*x*z + x*y: t1=x*y; t2=x*x; t2=t2*z; R=t2+t1.
  - Mode 1, 2 steps, x*y + z: t1=x*y; R=t1+z.
  - Mode 2, 2 steps, x*(y+z): t1=y+z; R=x*t1.
  - Mode 3, 3 steps, x*x - y*z: t1=x*x; t2=y*z; R=t1-t2.
  - After the last step, go to CHECK.
  - Every product and sum is truncated to W bits at each step; subtraction wraps.
- CHECK, one cycle, compares Result == Target:
  - Equal: go to SOLVED (Correct=1, Done=1).
  - Not equal: Wrong=1 for this cycle only and TriesLeft decrements.
    - If the new TriesLeft > 0, go to LOAD_X. Target and mode are retained; x, y, z are overwritten on re-entry.
    - If the new TriesLeft = 0, go to FAILED (Done=1, Correct=0).
- Latency: from the edge sampling Go=0 in WAIT_Z, Correct or FAILED is reached after N+1 edges (N = step count).
- SOLVED and FAILED hold their outputs until Start or Reset; Start gives a one-cycle exit to LOAD_X.
- Mode values are all legal; there is no illegal encoding.
- An unreachable state encoding falls back to IDLE.
- Correct, Done and Busy are decoded from state. Wrong is driven combinationally in CHECK from the registered compare.

Decomposition:
- Package equation_pkg holds:
  - Mode encodings: MODE_CUBIC=0, MODE_MAC=1, MODE_DIST=2, MODE_DIFF=3.
  - State enum.
  - ALU op enum: OP_ADD, OP_SUB, OP_MUL.
  - Operand-select enum: X, Y, Z, T1, T2.
  - Step-count constant per mode.
- Sub-module eq_alu: combinational, parametrised by W. Inputs a, b, op; output W-bit y.
- Controller and datapath registers stay in equation_checker; the micro-op table is a case on {mode, step}.

Test Plan:
- Mode 0 correct on first try, W=8: Start with timer=22; enter x=2, y=3, z=4.
  - Required: Result=22, Correct=1, Done=1, TriesLeft=3, Wrong never pulsed.
  - Required: SOLVED reached exactly 5 edges after Go falls.
- Mode 3 wrap: target 127; enter x=3, y=5, z=2.
  - Required: Result=255, a single-cycle Wrong pulse, TriesLeft=2, state returns to LOAD_X.
- Mode 2 overflow: target 0; enter x=16, y=8, z=8.
  - Required: Result=0 (256 mod 256), Correct=1.
- Tries exhaustion, MAX_TRIES=3, mode 1, target 50: submit (1,1,1) three times.
  - Required: three Wrong pulses, TriesLeft 2→1→0, FAILED with Done=1, Correct=0.
  - Then Start: TriesLeft=3, Target relatched.
- Reset mid-EVAL (mode 0, step 2): assert Reset asynchronously.
  - Required: all outputs 0 and TriesLeft=MAX_TRIES immediately; IDLE after release.
  - Required: Start pulses during LOAD_Y are ignored.
- Go held high across several cycles in LOAD_X with DataIn changing 5→9.
  - Required: x captures the value present in the first Go=1 cycle (5); y is not loaded until Go falls and rises again.

Source files
------------

// File: rtl/equation_pkg.sv
// Shared encodings for the equation checker: modes, controller states and
// the micro-op vocabulary used by the evaluation sequencer.
package equation_pkg;

    localparam logic [1:0] MODE_CUBIC = 2'd0;
    localparam logic [1:0] MODE_MAC   = 2'd1;
    localparam logic [1:0] MODE_DIST  = 2'd2;
    localparam logic [1:0] MODE_DIFF  = 2'd3;

    localparam logic [2:0] STEPS_CUBIC = 3'd4;
    localparam logic [2:0] STEPS_MAC   = 3'd2;
    localparam logic [2:0] STEPS_DIST  = 3'd2;
    localparam logic [2:0] STEPS_DIFF  = 3'd3;

    typedef enum logic [3:0] {
        IDLE, LOAD_X, WAIT_X, LOAD_Y, WAIT_Y, LOAD_Z, WAIT_Z,
        EVAL, CHECK, SOLVED, FAILED
    } state_e;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} alu_op_e;

    typedef enum logic [2:0] {X, Y, Z, T1, T2} operand_e;

    typedef enum logic [1:0] {DST_T1, DST_T2, DST_R} dest_e;

    function automatic logic [2:0] step_count(input logic [1:0] mode);
        case (mode)
            MODE_CUBIC: return STEPS_CUBIC;
            MODE_MAC:   return STEPS_MAC;
            MODE_DIST:  return STEPS_DIST;
            default:    return STEPS_DIFF;
        endcase
    endfunction

endpackage

// File: rtl/eq_alu.sv
// Shared combinational ALU; every result is truncated to W bits.
module eq_alu
    import equation_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  alu_op_e      i_op,
    output logic [W-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_MUL:  o_y = i_a * i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/equation_checker.sv
// Puzzle round controller: latches a target, collects x/y/z via a Go
// handshake, evaluates the selected equation one ALU op per cycle, then checks.
module equation_checker
    import equation_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned TIMER_W   = 7,
    parameter int unsigned MAX_TRIES = 3,
    parameter int unsigned TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic               i_go,
    input  logic [TIMER_W-1:0] i_ongoing_timer,
    input  logic [W-1:0]       i_data_in,
    output logic               o_busy,
    output logic               o_correct,
    output logic               o_wrong,
    output logic               o_done,
    output logic [TRY_W-1:0]   o_tries_left,
    output logic [W-1:0]       o_result,
    output logic [W-1:0]       o_target
);

    state_e           r_state, w_state_nxt;
    logic [W-1:0]     r_x, r_y, r_z, r_t1, r_t2, r_result, r_target;
    logic [1:0]       r_mode;
    logic [1:0]       r_step;
    logic [TRY_W-1:0] r_tries;

    alu_op_e          w_op;
    operand_e         w_sel_a, w_sel_b;
    dest_e            w_dst;
    logic             w_last;
    logic [W-1:0]     w_a, w_b, w_alu_y;
    logic             w_match;
    logic [TRY_W-1:0] w_tries_dec;

    assign w_match     = (r_result == r_target);
    assign w_tries_dec = r_tries - TRY_W'(1);
    assign w_last      = ((3'(r_step) + 3'd1) == step_count(r_mode));

    // Micro-op table indexed by {mode, step}
    always_comb begin
        w_op    = OP_ADD;
        w_sel_a = X;
        w_sel_b = Y;
        w_dst   = DST_R;
        case ({r_mode, r_step})
            {MODE_CUBIC, 2'd0}: begin w_op = OP_MUL; w_sel_a = X;  w_sel_b = Y;  w_dst = DST_T1; end
            {MODE_CUBIC, 2'd1}: begin w_op = OP_MUL; w_sel_a = X;  w_sel_b = X;  w_dst = DST_T2; end
            {MODE_CUBIC, 2'd2}: begin w_op = OP_MUL; w_sel_a = T2; w_sel_b = Z;  w_dst = DST_T2; end
            {MODE_CUBIC, 2'd3}: begin w_op = OP_ADD; w_sel_a = T2; w_sel_b = T1; w_dst = DST_R;  end
            {MODE_MAC,   2'd0}: begin w_op = OP_MUL; w_sel_a = X;  w_sel_b = Y;  w_dst = DST_T1; end
            {MODE_MAC,   2'd1}: begin w_op = OP_ADD; w_sel_a = T1; w_sel_b = Z;  w_dst = DST_R;  end
            {MODE_DIST,  2'd0}: begin w_op = OP_ADD; w_sel_a = Y;  w_sel_b = Z;  w_dst = DST_T1; end
            {MODE_DIST,  2'd1}: begin w_op = OP_MUL; w_sel_a = X;  w_sel_b = T1; w_dst = DST_R;  end
            {MODE_DIFF,  2'd0}: begin w_op = OP_MUL; w_sel_a = X;  w_sel_b = X;  w_dst = DST_T1; end
            {MODE_DIFF,  2'd1}: begin w_op = OP_MUL; w_sel_a = Y;  w_sel_b = Z;  w_dst = DST_T2; end
            {MODE_DIFF,  2'd2}: begin w_op = OP_SUB; w_sel_a = T1; w_sel_b = T2; w_dst = DST_R;  end
            default: ;
        endcase
    end

    always_comb begin
        w_a = r_x;
        w_b = r_y;
        case (w_sel_a)
            X:       w_a = r_x;
            Y:       w_a = r_y;
            Z:       w_a = r_z;
            T1:      w_a = r_t1;
            T2:      w_a = r_t2;
            default: w_a = r_x;
        endcase
        case (w_sel_b)
            X:       w_b = r_x;
            Y:       w_b = r_y;
            Z:       w_b = r_z;
            T1:      w_b = r_t1;
            T2:      w_b = r_t2;
            default: w_b = r_y;
        endcase
    end

    eq_alu #(.W(W)) u_alu (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_op (w_op),
        .o_y  (w_alu_y)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, SOLVED, FAILED: if (i_start) w_state_nxt = LOAD_X;
            LOAD_X: if (i_go)  w_state_nxt = WAIT_X;
            WAIT_X: if (!i_go) w_state_nxt = LOAD_Y;
            LOAD_Y: if (i_go)  w_state_nxt = WAIT_Y;
            WAIT_Y: if (!i_go) w_state_nxt = LOAD_Z;
            LOAD_Z: if (i_go)  w_state_nxt = WAIT_Z;
            WAIT_Z: if (!i_go) w_state_nxt = EVAL;
            EVAL:   if (w_last) w_state_nxt = CHECK;
            CHECK: begin
                if (w_match)                 w_state_nxt = SOLVED;
                else if (w_tries_dec == '0)  w_state_nxt = FAILED;
                else                         w_state_nxt = LOAD_X;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath registers; operands are simply overwritten on a retry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_result <= '0;
            r_target <= '0;
            r_mode   <= '0;
            r_step   <= '0;
            r_tries  <= TRY_W'(MAX_TRIES);
        end else begin
            case (r_state)
                IDLE, SOLVED, FAILED: begin
                    if (i_start) begin
                        r_target <= W'(i_ongoing_timer);
                        r_mode   <= i_mode;
                        r_tries  <= TRY_W'(MAX_TRIES);
                        r_result <= '0;
                    end
                end
                LOAD_X: if (i_go) r_x <= i_data_in;
                LOAD_Y: if (i_go) r_y <= i_data_in;
                LOAD_Z: if (i_go) r_z <= i_data_in;
                WAIT_Z: r_step <= '0;
                EVAL: begin
                    r_step <= r_step + 2'd1;
                    case (w_dst)
                        DST_T1:  r_t1     <= w_alu_y;
                        DST_T2:  r_t2     <= w_alu_y;
                        default: r_result <= w_alu_y;
                    endcase
                end
                CHECK: if (!w_match) r_tries <= w_tries_dec;
                default: ;
            endcase
        end
    end

    assign o_busy       = !((r_state == IDLE) || (r_state == SOLVED) || (r_state == FAILED));
    assign o_correct    = (r_state == SOLVED);
    assign o_done       = (r_state == SOLVED) || (r_state == FAILED);
    assign o_wrong      = (r_state == CHECK) && !w_match;
    assign o_tries_left = r_tries;
    assign o_result     = r_result;
    assign o_target     = r_target;

endmodule

// File: tb/tb_equation_checker.sv
// Randomised bench for equation_checker against a transaction-level model of
// the round (target, tries, outcome) with per-cycle output comparison.
module tb_equation_checker;

    localparam int W         = 8;
    localparam int TIMER_W   = 7;
    localparam int MAX_TRIES = 3;
    localparam int TRY_W     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         mode;
    logic               go;
    logic [TIMER_W-1:0] timer;
    logic [W-1:0]       din;
    logic               busy, correct, wrong, done;
    logic [TRY_W-1:0]   tries;
    logic [W-1:0]       result, target;

    int errors = 0;
    int checks = 0;

    bit m_busy, m_done, m_correct, m_wrong, m_res_valid;
    int m_tries, m_target, m_result, m_mode;

    equation_checker #(
        .W(W), .TIMER_W(TIMER_W), .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_mode          (mode),
        .i_go            (go),
        .i_ongoing_timer (timer),
        .i_data_in       (din),
        .o_busy          (busy),
        .o_correct       (correct),
        .o_wrong         (wrong),
        .o_done          (done),
        .o_tries_left    (tries),
        .o_result        (result),
        .o_target        (target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_eval(input int md, input int x, input int y, input int z);
        int r;
        case (md)
            0:       r = x * x * z + x * y;
            1:       r = x * y + z;
            2:       r = x * (y + z);
            default: r = x * x - y * z;
        endcase
        return r & ((1 << W) - 1);
    endfunction

    function automatic int steps_of(input int md);
        case (md)
            0:       return 4;
            1:       return 2;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_correct = 0; m_wrong = 0;
        m_tries = MAX_TRIES; m_target = 0; m_result = 0; m_res_valid = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs compared against the model on every falling edge
    always @(negedge clk) begin
        check("busy",    int'(busy),    int'(m_busy));
        check("done",    int'(done),    int'(m_done));
        check("correct", int'(correct), int'(m_correct));
        check("wrong",   int'(wrong),   int'(m_wrong));
        check("tries",   int'(tries),   m_tries);
        check("target",  int'(target),  m_target);
        if (m_res_valid) check("result", int'(result), m_result);
    end

    task automatic start_round(input int md, input int tm);
        start = 1'b1;
        mode  = 2'(md);
        timer = TIMER_W'(tm);
        tick();
        start = 1'b0;
        mode  = 2'($urandom);
        timer = TIMER_W'($urandom);
        m_busy = 1; m_done = 0; m_correct = 0;
        m_tries = MAX_TRIES; m_target = tm; m_mode = md;
        m_result = 0; m_res_valid = 1;
    endtask

    task automatic submit(input int x, input int y, input int z, input int hold,
                          input int alt, input bit poke, input bit abort,
                          output bit solved);
        solved = 0;
        go = 1'b1; din = W'(x); tick();
        repeat (hold) begin din = W'(alt); tick(); end
        go = 1'b0; tick();
        if (poke) begin
            start = 1'b1; timer = TIMER_W'($urandom); mode = 2'($urandom);
            tick();
            start = 1'b0;
        end
        go = 1'b1; din = W'(y); tick();
        go = 1'b0; tick();
        go = 1'b1; din = W'(z); tick();
        go = 1'b0; tick();
        m_res_valid = 0;
        if (abort) begin
            tick();
            tick();
            #2 rst = 1'b1;
            #1 model_reset();
            check("arst_busy",   int'(busy),   0);
            check("arst_tries",  int'(tries),  MAX_TRIES);
            check("arst_result", int'(result), 0);
            check("arst_target", int'(target), 0);
            @(posedge clk);
            #3 rst = 1'b0;
            tick();
            check("arst_idle", int'(busy | done), 0);
            return;
        end
        repeat (steps_of(m_mode)) tick();
        m_result    = model_eval(m_mode, x, y, z);
        m_res_valid = 1;
        solved      = (m_result == m_target);
        m_wrong     = !solved;
        tick();
        m_wrong = 0;
        if (solved) begin
            m_busy = 0; m_done = 1; m_correct = 1;
        end else begin
            m_tries--;
            if (m_tries == 0) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; go = 1'b0; mode = '0; timer = '0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("reset_tries",  int'(tries),  3);
        check("reset_target", int'(target), 0);

        // Mode 0 solved first time: 2*2*4 + 2*3 = 22
        start_round(0, 22);
        submit(2, 3, 4, 0, 0, 0, 0, ok);
        check("cubic_result",  int'(result),  22);
        check("cubic_correct", int'(correct), 1);
        check("cubic_tries",   int'(tries),   3);

        // Mode 3 wraps: 9 - 10 = 255, then 144 - 17 = 127
        start_round(3, 127);
        submit(3, 5, 2, 0, 0, 0, 0, ok);
        check("diff_result", int'(result), 255);
        check("diff_tries",  int'(tries),  2);
        check("diff_retry",  int'(busy),   1);
        submit(12, 1, 17, 0, 0, 0, 0, ok);
        check("diff_solved", int'(result), 127);

        // Mode 2 overflow: 16 * 16 = 256 -> 0
        start_round(2, 0);
        submit(16, 8, 8, 0, 0, 0, 0, ok);
        check("dist_result",  int'(result),  0);
        check("dist_correct", int'(correct), 1);

        // Exhaustion: 1*1 + 1 = 2 never matches 50
        start_round(1, 50);
        for (int k = 0; k < MAX_TRIES; k++) begin
            submit(1, 1, 1, 0, 0, 0, 0, ok);
            check("exhaust_tries", int'(tries), MAX_TRIES - 1 - k);
        end
        check("failed_done",    int'(done),    1);
        check("failed_correct", int'(correct), 0);

        // Restart relatches; Go held across DataIn 5 -> 9; Start poked in LOAD_Y
        start_round(1, 11);
        check("restart_tries",  int'(tries),  3);
        check("restart_target", int'(target), 11);
        submit(5, 2, 1, 3, 9, 1, 0, ok);
        check("hold_result", int'(result), 11);

        // Async reset in the middle of a mode 0 evaluation
        start_round(0, 22);
        submit(2, 3, 4, 0, 0, 0, 1, ok);

        for (int r = 0; r < 150; r++) begin
            int md, tm, x, y, z;
            bit hit;
            md = int'($urandom_range(0, 3));
            tm = int'($urandom_range(0, (1 << TIMER_W) - 1));
            start_round(md, tm);
            ok = 0;
            while (!ok && m_tries > 0) begin
                x = int'($urandom_range(0, 255));
                y = int'($urandom_range(0, 255));
                z = int'($urandom_range(0, 255));
                hit = ($urandom_range(0, 3) == 0);
                if (hit) begin
                    case (md)
                        0:       begin x = 1; z = (tm - y) & 255; end
                        1:       z = (tm - x * y) & 255;
                        2:       begin x = 1; z = (tm - y) & 255; end
                        default: begin y = 1; z = (x * x - tm) & 255; end
                    endcase
                end
                submit(x, y, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0), 0, ok);
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
